// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with operand select, forwarding and
//            load-use bubble insertion; ID_EX_FWD_EN enables MEM/WB forwarding
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int WordSize = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [WordSize-1:0] id_pc,
  input  logic [WordSize-1:0] id_rs1_data,
  input  logic [WordSize-1:0] id_rs2_data,
  input  logic [WordSize-1:0] id_imm,
  input  logic [4:0]          id_rs1_addr,
  input  logic [4:0]          id_rs2_addr,
  input  logic [4:0]          id_rd_addr,
  input  logic [4:0]          id_alu_op,
  input  logic                id_a_sel,
  input  logic                id_b_sel,
  input  logic                id_rd_we,
  input  logic                id_is_load,
  input  logic [4:0]          mem_rd_addr,
  input  logic                mem_rd_we,
  input  logic [WordSize-1:0] mem_result,
  input  logic [4:0]          wb_rd_addr,
  input  logic                wb_rd_we,
  input  logic [WordSize-1:0] wb_result,
  output logic                ex_valid,
  output logic [WordSize-1:0] ex_operand_a,
  output logic [WordSize-1:0] ex_operand_b,
  output logic [3:0]          ex_op_code_1,
  output logic                ex_op_code_2,
  output logic [WordSize-1:0] ex_rs2_data,
  output logic [WordSize-1:0] ex_pc,
  output logic [4:0]          ex_rd_addr,
  output logic                ex_rd_we,
  output logic                ex_is_load,
  output logic                load_use_stall
);

  typedef struct packed {
    logic                valid;
    logic [WordSize-1:0] operand_a;
    logic [WordSize-1:0] operand_b;
    logic [4:0]          alu_op;
    logic [WordSize-1:0] rs2_data;
    logic [WordSize-1:0] pc;
    logic [4:0]          rd_addr;
    logic                rd_we;
    logic                is_load;
  } ex_t;

  localparam ex_t Bubble = '0;

  ex_t                 ex_q;
  ex_t                 ex_d;
  logic [WordSize-1:0] fwd_rs1;
  logic [WordSize-1:0] fwd_rs2;
  logic                ex_hit;

  assign ex_hit = (ex_q.rd_addr != 5'd0) &&
                  ((ex_q.rd_addr == id_rs1_addr) || (ex_q.rd_addr == id_rs2_addr));

`ifdef ID_EX_FWD_EN
  function automatic logic [WordSize-1:0] fwd_sel(
    input logic [4:0]          rs,
    input logic [WordSize-1:0] rf_data,
    input logic [4:0]          m_rd,
    input logic                m_we,
    input logic [WordSize-1:0] m_res,
    input logic [4:0]          w_rd,
    input logic                w_we,
    input logic [WordSize-1:0] w_res
  );
    if (rs != 5'd0 && m_we && m_rd == rs) begin
      return m_res;
    end else if (rs != 5'd0 && w_we && w_rd == rs) begin
      return w_res;
    end
    return rf_data;
  endfunction

  always_comb begin
    fwd_rs1 = fwd_sel(id_rs1_addr, id_rs1_data, mem_rd_addr, mem_rd_we, mem_result,
                      wb_rd_addr, wb_rd_we, wb_result);
    fwd_rs2 = fwd_sel(id_rs2_addr, id_rs2_data, mem_rd_addr, mem_rd_we, mem_result,
                      wb_rd_addr, wb_rd_we, wb_result);
    load_use_stall = ex_q.valid && ex_q.is_load && ex_q.rd_we && ex_hit && id_valid;
  end
`else
  logic mem_hit;
  logic unused_fwd_inputs;

  // Without forwarding every RAW dependency on EX or MEM must wait for the
  // register file; WB is safe because the file writes before it reads.
  assign mem_hit = mem_rd_we && (mem_rd_addr != 5'd0) &&
                   ((mem_rd_addr == id_rs1_addr) || (mem_rd_addr == id_rs2_addr));
  assign unused_fwd_inputs = ^{mem_result, wb_rd_addr, wb_rd_we, wb_result};

  always_comb begin
    fwd_rs1        = id_rs1_data;
    fwd_rs2        = id_rs2_data;
    load_use_stall = id_valid && ((ex_q.valid && ex_q.rd_we && ex_hit) || mem_hit);
  end
`endif

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = Bubble;
    end else if (stall) begin
      ex_d = ex_q;
    end else if (load_use_stall || !id_valid) begin
      ex_d = Bubble;
    end else begin
      ex_d.valid     = 1'b1;
      ex_d.operand_a = id_a_sel ? id_pc  : fwd_rs1;
      ex_d.operand_b = id_b_sel ? id_imm : fwd_rs2;
      ex_d.alu_op    = id_alu_op;
      ex_d.rs2_data  = fwd_rs2;
      ex_d.pc        = id_pc;
      ex_d.rd_addr   = id_rd_addr;
      ex_d.rd_we     = id_rd_we;
      ex_d.is_load   = id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= Bubble;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_operand_a = ex_q.operand_a;
  assign ex_operand_b = ex_q.operand_b;
  assign ex_op_code_1 = ex_q.alu_op[3:0];
  assign ex_op_code_2 = ex_q.alu_op[4];
  assign ex_rs2_data  = ex_q.rs2_data;
  assign ex_pc        = ex_q.pc;
  assign ex_rd_addr   = ex_q.rd_addr;
  assign ex_rd_we     = ex_q.rd_we;
  assign ex_is_load   = ex_q.is_load;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Directed plus randomized bench for id_ex_stage against a
//            rule-level reference model (honours ID_EX_FWD_EN)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, stall, flush, id_valid;
  logic [W-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]   id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op;
  logic         id_a_sel, id_b_sel, id_rd_we, id_is_load;
  logic [4:0]   mem_rd_addr, wb_rd_addr;
  logic         mem_rd_we, wb_rd_we;
  logic [W-1:0] mem_result, wb_result;
  logic         ex_valid, ex_op_code_2, ex_rd_we, ex_is_load, load_use_stall;
  logic [W-1:0] ex_operand_a, ex_operand_b, ex_rs2_data, ex_pc;
  logic [3:0]   ex_op_code_1;
  logic [4:0]   ex_rd_addr;

  id_ex_stage #(.WordSize(W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_alu_op(id_alu_op), .id_a_sel(id_a_sel),
    .id_b_sel(id_b_sel), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .mem_rd_addr(mem_rd_addr), .mem_rd_we(mem_rd_we), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_operand_a(ex_operand_a), .ex_operand_b(ex_operand_b),
    .ex_op_code_1(ex_op_code_1), .ex_op_code_2(ex_op_code_2),
    .ex_rs2_data(ex_rs2_data), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr),
    .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the instruction currently expected in EX
  logic         m_valid, m_we, m_load;
  logic [W-1:0] m_a, m_b, m_rs2, m_pc;
  logic [4:0]   m_op, m_rd;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_fwd(input logic [4:0] rs, input logic [W-1:0] rf);
`ifdef ID_EX_FWD_EN
    if (rs != 0 && mem_rd_we && mem_rd_addr == rs) return mem_result;
    if (rs != 0 && wb_rd_we && wb_rd_addr == rs) return wb_result;
`endif
    return rf;
  endfunction

  function automatic logic reads(input logic [4:0] rd);
    return rd != 0 && (rd == id_rs1_addr || rd == id_rs2_addr);
  endfunction

  function automatic logic model_lus();
`ifdef ID_EX_FWD_EN
    return id_valid && m_valid && m_load && m_we && reads(m_rd);
`else
    return id_valid && ((m_valid && m_we && reads(m_rd)) || (mem_rd_we && reads(mem_rd_addr)));
`endif
  endfunction

  task automatic model_bubble();
    m_valid = 0; m_we = 0; m_load = 0; m_a = 0; m_b = 0; m_rs2 = 0; m_pc = 0; m_op = 0; m_rd = 0;
  endtask

  task automatic check_all();
    chk("ex_valid", W'(ex_valid), W'(m_valid));
    chk("ex_operand_a", ex_operand_a, m_a);
    chk("ex_operand_b", ex_operand_b, m_b);
    chk("ex_op_code_1", W'(ex_op_code_1), W'(m_op[3:0]));
    chk("ex_op_code_2", W'(ex_op_code_2), W'(m_op[4]));
    chk("ex_rs2_data", ex_rs2_data, m_rs2);
    chk("ex_pc", ex_pc, m_pc);
    chk("ex_rd_addr", W'(ex_rd_addr), W'(m_rd));
    chk("ex_rd_we", W'(ex_rd_we), W'(m_we));
    chk("ex_is_load", W'(ex_is_load), W'(m_load));
    chk("load_use_stall", W'(load_use_stall), W'(model_lus()));
  endtask

  // Compare at the falling edge, advance the model, then cross the rising edge
  task automatic cyc();
    @(negedge clk);
    check_all();
    if (rst || flush) model_bubble();
    else if (stall) ;
    else if (model_lus() || !id_valid) model_bubble();
    else begin
      m_valid = 1;
      m_a     = id_a_sel ? id_pc : model_fwd(id_rs1_addr, id_rs1_data);
      m_b     = id_b_sel ? id_imm : model_fwd(id_rs2_addr, id_rs2_data);
      m_rs2   = model_fwd(id_rs2_addr, id_rs2_data);
      m_pc    = id_pc;
      m_op    = id_alu_op;
      m_rd    = id_rd_addr;
      m_we    = id_rd_we;
      m_load  = id_is_load;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; flush = 0; id_valid = 0; id_pc = 0; id_rs1_data = 0;
    id_rs2_data = 0; id_imm = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
    id_alu_op = 0; id_a_sel = 0; id_b_sel = 0; id_rd_we = 0; id_is_load = 0;
    mem_rd_addr = 0; mem_rd_we = 0; mem_result = 0; wb_rd_addr = 0; wb_rd_we = 0; wb_result = 0;
  endtask

  task automatic randomize_inputs();
    rst         = ($urandom_range(0, 63) == 0);
    flush       = ($urandom_range(0, 15) == 0);
    stall       = ($urandom_range(0, 7) == 0);
    id_valid    = ($urandom_range(0, 4) != 0);
    id_pc       = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_rs1_addr = 5'($urandom_range(0, 3));
    id_rs2_addr = 5'($urandom_range(0, 3));
    id_rd_addr  = 5'($urandom_range(0, 3));
    id_alu_op   = 5'($urandom);
    id_a_sel    = 1'($urandom); id_b_sel = 1'($urandom);
    id_rd_we    = 1'($urandom); id_is_load = 1'($urandom);
    mem_rd_addr = 5'($urandom_range(0, 3)); mem_rd_we = 1'($urandom); mem_result = $urandom;
    wb_rd_addr  = 5'($urandom_range(0, 3)); wb_rd_we = 1'($urandom); wb_result = $urandom;
  endtask

  initial begin
    model_bubble();
    idle_inputs();
    #1;

    // Reset for two cycles: all outputs must read as the bubble
    rst = 1; id_valid = 1; id_rs1_data = 32'h99;
    cyc(); cyc();
    chk("reset ex_valid", W'(ex_valid), 0);
    chk("reset ex_operand_a", ex_operand_a, 0);
    chk("reset load_use_stall", W'(load_use_stall), 0);

    // Basic capture with a 1-cycle latency
    idle_inputs();
    id_valid = 1; id_rs1_data = 5; id_rs2_data = 7; id_alu_op = 5'h10;
    id_rs1_addr = 1; id_rs2_addr = 2; id_rd_addr = 3; id_rd_we = 0;
    cyc();
    chk("cap operand_a", ex_operand_a, 5);
    chk("cap operand_b", ex_operand_b, 7);
    chk("cap op_code_2", W'(ex_op_code_2), 1);
    chk("cap op_code_1", W'(ex_op_code_1), 0);
    chk("cap valid", W'(ex_valid), 1);

`ifdef ID_EX_FWD_EN
    // Forward priority MEM > WB > register file; x0 never forwards
    idle_inputs();
    id_valid = 1; id_rs1_addr = 3; id_rs1_data = 32'h11;
    mem_rd_addr = 3; mem_rd_we = 1; mem_result = 32'hAA;
    wb_rd_addr = 3; wb_rd_we = 1; wb_result = 32'hBB;
    cyc();
    chk("fwd mem", ex_operand_a, 32'hAA);
    mem_rd_we = 0;
    cyc();
    chk("fwd wb", ex_operand_a, 32'hBB);
    id_rs1_addr = 0; mem_rd_addr = 0; mem_rd_we = 1; wb_rd_addr = 0; id_rs1_data = 32'h55;
    cyc();
    chk("fwd x0", ex_operand_a, 32'h55);
`else
    // No forwarding: a MEM writer to rs1 stalls, then register data passes
    idle_inputs();
    id_valid = 1; id_rs1_addr = 6; id_rs1_data = 32'h66;
    mem_rd_addr = 6; mem_rd_we = 1; mem_result = 32'hAA;
    #1;
    chk("raw mem lus", W'(load_use_stall), 1);
    cyc();
    chk("raw mem bubble", W'(ex_valid), 0);
    mem_rd_we = 0;
    cyc();
    chk("no fwd operand_a", ex_operand_a, 32'h66);
`endif

    // Load in EX to x4, decode reads x4 through rs2
    idle_inputs();
    id_valid = 1; id_rd_addr = 4; id_rd_we = 1; id_is_load = 1; id_rs1_addr = 9; id_rs2_addr = 10;
    cyc();
    idle_inputs();
    id_valid = 1; id_rs2_addr = 4; id_rs2_data = 32'h44; id_rd_addr = 5;
    mem_rd_addr = 4; mem_rd_we = 1; mem_result = 32'hCC;
    #1;
    chk("load-use lus", W'(load_use_stall), 1);
    cyc();
    chk("load-use bubble", W'(ex_valid), 0);
`ifdef ID_EX_FWD_EN
    cyc();
    chk("load-use fwd b", ex_operand_b, 32'hCC);
    chk("load-use fwd rs2", ex_rs2_data, 32'hCC);
`endif

    // Stall holds EX while decode changes
    idle_inputs();
    id_valid = 1; id_a_sel = 1; id_pc = 32'h10;
    cyc();
    for (int i = 0; i < 3; i++) begin
      stall = 1; id_pc = $urandom; id_rs1_data = $urandom; id_valid = 1'($urandom);
      cyc();
      chk("stall hold a", ex_operand_a, 32'h10);
      chk("stall hold valid", W'(ex_valid), 1);
    end

    // Flush beats stall
    idle_inputs();
    id_valid = 1; id_rd_we = 1; id_rd_addr = 7; id_alu_op = 5'h1F;
    cyc();
    flush = 1; stall = 1;
    cyc();
    chk("flush valid", W'(ex_valid), 0);
    chk("flush rd_we", W'(ex_rd_we), 0);
    chk("flush op", W'(ex_op_code_1), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register that directly feeds the ALU: operand_a, operand_b, op_code_1, op_code_2.
- Selects ALU operands (rs1/pc, rs2/imm) and applies EX/MEM and MEM/WB result forwarding before registering.
- Detects load-use hazards and inserts bubbles.
- Handles downstream stall (hold) and branch flush (bubble).

Parameters:
- WordSize, 32, datapath width; matches ALU WordSize.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  downstream hold; EX registers keep their value
- flush  in  1  replace the next EX contents with a bubble
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  WordSize  instruction PC
- id_rs1_data, id_rs2_data  in  WordSize  register file read data
- id_imm  in  WordSize  sign-extended immediate
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  5  register indices
- id_alu_op  in  5  {op_code_2, op_code_1} ALU encoding
- id_a_sel  in  1  0 = rs1, 1 = pc
- id_b_sel  in  1  0 = rs2, 1 = imm
- id_rd_we  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- mem_rd_addr  in  5;  mem_rd_we  in  1;  mem_result  in  WordSize  EX/MEM forward source
- wb_rd_addr  in  5;  wb_rd_we  in  1;  wb_result  in  WordSize  MEM/WB forward source
- ex_valid  out  1  EX slot holds a real instruction
- ex_operand_a, ex_operand_b  out  WordSize  ALU operands
- ex_op_code_1  out  4;  ex_op_code_2  out  1  ALU opcode fields
- ex_rs2_data  out  WordSize  forwarded store data
- ex_pc  out  WordSize;  ex_rd_addr  out  5;  ex_rd_we  out  1;  ex_is_load  out  1
- load_use_stall  out  1  combinational; decode must hold while high

Behaviour:
- Bubble value: ex_valid=0, opcode fields 0 (ADD), ex_rd_we=0, ex_is_load=0, all data/address outputs 0.
- Reset: every output register takes the bubble value on the first edge with rst=1. load_use_stall is 0 while ex_valid=0.
- Per-edge priority: rst > flush > stall (hold all) > load_use_stall (bubble) > capture decode inputs.
- Capture latency is 1 cycle: decode inputs at edge N appear on ex_* after edge N.
- id_valid=0 captures as a bubble.
- Forwarding is combinational, applied to rs1 and rs2 before operand select:
  - Priority: MEM (mem_rd_we and mem_rd_addr==rs) over WB (wb_rd_we and wb_rd_addr==rs) over register file data.
  - Register index 0 never forwards.
- Operand select after forwarding:
  - operand_a = id_a_sel ? id_pc : fwd_rs1
  - operand_b = id_b_sel ? id_imm : fwd_rs2
  - ex_rs2_data always takes fwd_rs2.
- load_use_stall = ex_valid & ex_is_load & ex_rd_we & (ex_rd_addr!=0) & id_valid & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr). This is conservative: it ignores the sel bits.
- stall and load_use_stall together: stall wins and EX holds. The load stays in EX, so load_use_stall stays high.
- flush and stall together: flush wins and a bubble is inserted.
- Widths are exact. No arithmetic is done in this block; the ALU computes.

Optional Feature:
- Macro ID_EX_FWD_EN.
- Defined: MEM/WB forwarding as described; load_use_stall covers the load-in-EX case only.
- Undefined: no forwarding muxes; mem_*/wb_* inputs are ignored for data. load_use_stall asserts on any RAW hazard:
  - Any valid EX writer (ex_valid & ex_rd_we) with ex_rd_addr matching rs1/rs2, or
  - Any MEM writer (mem_rd_we) with mem_rd_addr matching rs1/rs2,
  - in both cases only for a nonzero rd and id_valid=1.
- WB is not checked; the register file writes before it reads.

Test Plan:
- Reset then capture: rst=1 for 2 cycles, then id_valid=1, rs1_data=5, rs2_data=7, alu_op=5'h10, sels 0 → ex_operand_a=5, ex_operand_b=7, ex_op_code_2=1, ex_op_code_1=0, ex_valid=1 one cycle later. All outputs 0 during reset.
- Forward priority: rs1=3, mem_rd_addr=3 with mem_result=0xAA, wb_rd_addr=3 with wb_result=0xBB, both we=1 → ex_operand_a=0xAA. Set mem_rd_we=0 → 0xBB. Set rs1=0 with all sources targeting 0 → register file data passes.
- Load-use: EX holds a load to x4; decode has rs2=4 → load_use_stall=1 and the next EX is a bubble. The following cycle the instruction captures with the mem_result forward.
- Stall hold: capture operand_a=0x10, then stall=1 for 3 cycles while decode inputs change → ex_* stays 0x10 and ex_valid stays 1.
- Flush over stall: flush=1 and stall=1 together → ex_valid=0, ex_rd_we=0, opcode 0 next cycle.
- Macro undefined: MEM writer rd=6, decode rs1=6 → load_use_stall=1 and ex_operand_a equals id_rs1_data (no forward).
